// File: rtl/ahb_reg_pkg.sv
// Shared types and AHB-Lite encodings for the AHB-to-register-bus bridge.
package ahb_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

endpackage

// File: rtl/ahb_strb_gen.sv
// Byte-strobe decoder: maps hsize and low address bits to lane strobes and
// flags sizes wider than the bus or addresses not aligned to the size.
module ahb_strb_gen #(
  parameter int DW = 32
) (
  input  logic [2:0]                 i_hsize,
  input  logic [$clog2(DW/8)-1:0]    i_addr,
  output logic [DW/8-1:0]            o_strb,
  output logic                       o_illegal
);
  localparam int NB = DW / 8;
  localparam int LB = $clog2(NB);

  logic w_too_wide;
  logic w_misaligned;

  always_comb begin
    w_too_wide   = (i_hsize > 3'(LB));
    w_misaligned = 1'b0;
    o_strb       = '0;
    if (!w_too_wide) begin
      w_misaligned = ((int'(i_addr) & ((1 << i_hsize) - 1)) != 0);
      // A lane is enabled when it falls in the same size-aligned block as the address
      for (int i = 0; i < NB; i++) begin
        if ((i >> i_hsize) == (int'(i_addr) >> i_hsize)) o_strb[i] = 1'b1;
      end
    end
    o_illegal = w_too_wide | w_misaligned;
  end

endmodule

// File: rtl/ahb_reg_bridge.sv
// AHB-Lite slave to simple register request bus, with wait-state stretching,
// two-cycle ERROR response and an optional access timeout.
module ahb_reg_bridge
  import ahb_reg_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic              hready,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [31:0]       haddr,
  input  logic [2:0]        hsize,
  input  logic [DW-1:0]     hwdata,
  output logic [DW-1:0]     hrdata,
  output logic              hreadyout,
  output logic              hresp,
  output logic              mreq,
  output logic              mwrite,
  output logic [AW-1:0]     maddr,
  output logic [DW/8-1:0]   mstrb,
  output logic [DW-1:0]     mdata,
  input  logic [DW-1:0]     sdata,
  input  logic              sready,
  input  logic              sresp
);
  localparam int NB = DW / 8;
  localparam int LB = $clog2(NB);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] WAIT_MAX  = CW'(TIMEOUT);

  state_t          r_state, w_next;
  logic [AW-1:0]   r_addr;
  logic            r_write;
  logic [NB-1:0]   r_strb;
  logic [CW-1:0]   r_wait;

  logic [NB-1:0]   w_strb;
  logic            w_illegal;
  logic            w_accept;
  logic            w_timeout;
  logic            w_unused;

  assign w_unused = ^{haddr[31:AW], htrans[0]};

  ahb_strb_gen #(.DW(DW)) u_strb_gen (
    .i_hsize   (hsize),
    .i_addr    (haddr[LB-1:0]),
    .o_strb    (w_strb),
    .o_illegal (w_illegal)
  );

  // Only sample an address phase while this slave itself is ready
  assign w_accept  = hsel & hready & htrans[1] & hreadyout;
  assign w_timeout = (TIMEOUT != 0) && !sready && (r_wait == WAIT_LAST);

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_strb  <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= haddr[AW-1:0];
        r_write <= hwrite;
        r_strb  <= w_strb;
        r_wait  <= '0;
      end else if (r_state == ST_ACCESS && !sready && r_wait != WAIT_MAX) begin
        r_wait <= r_wait + CW'(1);
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    mreq      = 1'b0;
    hrdata    = '0;
    mdata     = '0;
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        hresp = (r_state == ST_ERR2);
        if (w_accept) w_next = w_illegal ? ST_ERR1 : ST_ACCESS;
        else          w_next = ST_IDLE;
      end
      ST_ACCESS: begin
        mreq      = 1'b1;
        mdata     = hwdata;
        hreadyout = sready & ~sresp;
        if (sready && sresp) begin
          w_next = ST_ERR1;
        end else if (sready) begin
          if (!r_write) hrdata = sdata;
          if (w_accept) w_next = w_illegal ? ST_ERR1 : ST_ACCESS;
          else          w_next = ST_IDLE;
        end else if (w_timeout) begin
          w_next = ST_ERR1;
        end
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        w_next    = ST_ERR2;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign mwrite = r_write;
  assign maddr  = r_addr;
  assign mstrb  = r_strb;

endmodule

// File: tb/tb_ahb_reg_bridge.sv
// Directed self-checking bench for ahb_reg_bridge (DW=32, AW=16, TIMEOUT=4).
module tb_ahb_reg_bridge;
  import ahb_reg_pkg::*;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic        hready;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;
  logic        mreq;
  logic        mwrite;
  logic [15:0] maddr;
  logic [3:0]  mstrb;
  logic [31:0] mdata;
  logic [31:0] sdata;
  logic        sready;
  logic        sresp;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  // Single-slave system: the bus ready is this slave's ready
  assign hready = hreadyout;

  ahb_reg_bridge #(.DW(32), .AW(16), .TIMEOUT(4)) dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .hready(hready),
    .htrans(htrans), .hwrite(hwrite), .haddr(haddr), .hsize(hsize),
    .hwdata(hwdata), .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp),
    .mreq(mreq), .mwrite(mwrite), .maddr(maddr), .mstrb(mstrb), .mdata(mdata),
    .sdata(sdata), .sready(sready), .sresp(sresp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic nonseq(input logic wr, input logic [31:0] a, input logic [2:0] sz);
    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = wr; haddr = a; hsize = sz;
  endtask

  task automatic no_phase();
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; haddr = '0; hsize = HSIZE_BYTE;
  endtask

  task automatic chk_resp(input string tag, input logic rdy, input logic rsp, input logic req);
    chk({tag, "_hreadyout"}, 32'(hreadyout), 32'(rdy));
    chk({tag, "_hresp"},     32'(hresp),     32'(rsp));
    chk({tag, "_mreq"},      32'(mreq),      32'(req));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    hreset = 1'b1;
    no_phase();
    hwdata = '0; sdata = '0; sready = 1'b0; sresp = 1'b0;
    #3;
    chk_resp("reset", 1'b1, 1'b0, 1'b0);
    chk("reset_maddr", 32'(maddr), 32'h0);
    chk("reset_mstrb", 32'(mstrb), 32'h0);
    chk("reset_mwrite", 32'(mwrite), 32'h0);
    chk("reset_hrdata", hrdata, 32'h0);
    cyc(); cyc();
    hreset = 1'b0;

    // Zero-wait write
    cyc();
    nonseq(1'b1, 32'h10, HSIZE_WORD);
    settle();
    chk("wr_addrphase_mreq", 32'(mreq), 32'h0);
    cyc();
    no_phase(); hwdata = 32'hA5A5_0001; sready = 1'b1;
    settle();
    chk_resp("wr_data", 1'b1, 1'b0, 1'b1);
    chk("wr_maddr", 32'(maddr), 32'h10);
    chk("wr_mstrb", 32'(mstrb), 32'hF);
    chk("wr_mwrite", 32'(mwrite), 32'h1);
    chk("wr_mdata", mdata, 32'hA5A5_0001);
    cyc();
    sready = 1'b0;
    settle();
    chk_resp("wr_after", 1'b1, 1'b0, 1'b0);

    // Read with 3 wait states
    cyc();
    nonseq(1'b0, 32'h24, HSIZE_WORD);
    cyc();
    no_phase(); sready = 1'b0; sdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_resp("rd_wait", 1'b0, 1'b0, 1'b1);
      cyc();
    end
    sready = 1'b1;
    settle();
    chk("rd_maddr", 32'(maddr), 32'h24);
    chk("rd_mwrite", 32'(mwrite), 32'h0);
    chk_resp("rd_done", 1'b1, 1'b0, 1'b1);
    chk("rd_hrdata", hrdata, 32'h1234_5678);
    cyc();
    sready = 1'b0;
    settle();
    chk("rd_after_hrdata", hrdata, 32'h0);
    chk_resp("rd_after", 1'b1, 1'b0, 1'b0);

    // Back-to-back byte then halfword, second accepted on the completing cycle
    cyc();
    nonseq(1'b1, 32'h3, HSIZE_BYTE);
    cyc();
    sready = 1'b1;
    nonseq(1'b1, 32'h2, HSIZE_HALF);
    settle();
    chk("b2b_byte_mstrb", 32'(mstrb), 32'h8);
    chk("b2b_byte_maddr", 32'(maddr), 32'h3);
    chk_resp("b2b_first", 1'b1, 1'b0, 1'b1);
    cyc();
    no_phase();
    settle();
    chk("b2b_half_mstrb", 32'(mstrb), 32'hC);
    chk("b2b_half_maddr", 32'(maddr), 32'h2);
    chk_resp("b2b_second", 1'b1, 1'b0, 1'b1);
    cyc();
    sready = 1'b0;
    settle();
    chk_resp("b2b_after", 1'b1, 1'b0, 1'b0);

    // Slave error
    cyc();
    nonseq(1'b0, 32'h40, HSIZE_WORD);
    cyc();
    no_phase(); sready = 1'b1; sresp = 1'b1;
    settle();
    chk_resp("serr_access", 1'b0, 1'b0, 1'b1);
    cyc();
    sready = 1'b0; sresp = 1'b0;
    settle();
    chk_resp("serr_err1", 1'b0, 1'b1, 1'b0);
    cyc();
    settle();
    chk_resp("serr_err2", 1'b1, 1'b1, 1'b0);
    cyc();
    settle();
    chk_resp("serr_idle", 1'b1, 1'b0, 1'b0);

    // Misaligned word, slave ready meanwhile must be ignored
    cyc();
    nonseq(1'b1, 32'h2, HSIZE_WORD);
    cyc();
    no_phase(); sready = 1'b1;
    settle();
    chk_resp("mis_err1", 1'b0, 1'b1, 1'b0);
    cyc();
    settle();
    chk_resp("mis_err2", 1'b1, 1'b1, 1'b0);
    cyc();
    sready = 1'b0;
    settle();
    chk_resp("mis_idle", 1'b1, 1'b0, 1'b0);

    // Size wider than the bus
    cyc();
    nonseq(1'b0, 32'h8, HSIZE_DWORD);
    cyc();
    no_phase();
    settle();
    chk_resp("wide_err1", 1'b0, 1'b1, 1'b0);
    cyc();
    settle();
    chk_resp("wide_err2", 1'b1, 1'b1, 1'b0);

    // Timeout after 4 ACCESS cycles
    cyc();
    nonseq(1'b0, 32'h50, HSIZE_WORD);
    cyc();
    no_phase(); sready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk_resp("tmo_wait", 1'b0, 1'b0, 1'b1);
      cyc();
    end
    settle();
    chk_resp("tmo_err1", 1'b0, 1'b1, 1'b0);
    cyc();
    settle();
    chk_resp("tmo_err2", 1'b1, 1'b1, 1'b0);

    // Asynchronous reset during ACCESS
    cyc();
    nonseq(1'b1, 32'h60, HSIZE_WORD);
    cyc();
    no_phase(); sready = 1'b0;
    settle();
    chk("rst_pre_mreq", 32'(mreq), 32'h1);
    chk("rst_pre_maddr", 32'(maddr), 32'h60);
    hreset = 1'b1;
    #1;
    chk_resp("rst_mid", 1'b1, 1'b0, 1'b0);
    chk("rst_mid_maddr", 32'(maddr), 32'h0);
    chk("rst_mid_mwrite", 32'(mwrite), 32'h0);
    chk("rst_mid_mstrb", 32'(mstrb), 32'h0);
    cyc();
    hreset = 1'b0;

    // Normal transfer after reset
    cyc();
    nonseq(1'b0, 32'h14, HSIZE_WORD);
    cyc();
    no_phase(); sready = 1'b1; sdata = 32'hCAFE_F00D;
    settle();
    chk("post_maddr", 32'(maddr), 32'h14);
    chk_resp("post_done", 1'b1, 1'b0, 1'b1);
    chk("post_hrdata", hrdata, 32'hCAFE_F00D);
    cyc();
    sready = 1'b0;
    settle();
    chk_resp("post_idle", 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
